// File: rtl/quad_enc_pkg.sv
// Shared types and transition decoder for the quadrature encoder counter.
// State encoding is {A, B}; the forward sequence is 00 -> 10 -> 11 -> 01.
package quad_enc_pkg;

  typedef enum logic [1:0] {
    QM_X1 = 2'd0,
    QM_X2 = 2'd1,
    QM_X4 = 2'd2
  } qenc_mode_e;

  typedef logic [1:0] qenc_state_t;

  localparam qenc_state_t ST_00 = 2'b00;
  localparam qenc_state_t ST_10 = 2'b10;
  localparam qenc_state_t ST_11 = 2'b11;
  localparam qenc_state_t ST_01 = 2'b01;

  typedef struct packed {
    logic count_en;
    logic up;
    logic illegal;
  } qenc_dec_t;

  function automatic qenc_dec_t qenc_decode(
    input qenc_state_t prev,
    input qenc_state_t curr,
    input logic [1:0]  mode
  );
    qenc_dec_t r;
    logic a_chg;
    logic b_chg;
    logic legal;
    logic x1_hit;
    a_chg     = prev[1] ^ curr[1];
    b_chg     = prev[0] ^ curr[0];
    legal     = a_chg ^ b_chg;
    r.illegal = a_chg & b_chg;
    r.up      = a_chg ? (curr[1] ^ curr[0])
                      : ~(curr[1] ^ curr[0]);
    x1_hit    = (prev == ST_00 && curr == ST_10) ||
                (prev == ST_10 && curr == ST_00);
    if (mode == QM_X1)
      r.count_en = legal & x1_hit;
    else if (mode == QM_X2)
      r.count_en = legal & a_chg;
    else
      r.count_en = legal;
    return r;
  endfunction

endpackage

// File: rtl/quad_enc_filt.sv
// Per-channel input synchroniser plus persistence filter.
// valid rises once the filtered output reflects a settled input.
module quad_enc_filt #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic valid
);

  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int VL = SYNC_STAGES + FILT_LEN;
  localparam int VW = $clog2(VL + 1);
  localparam logic [FW-1:0] F_LAST = FW'(FILT_LEN - 1);
  localparam logic [VW-1:0] V_LAST = VW'(VL);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FW-1:0]          fcnt_q, fcnt_d;
  logic [VW-1:0]          vcnt_q, vcnt_d;
  logic                   filt_q, filt_d;
  logic                   s;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    s      = sync_q[SYNC_STAGES-1];
    filt_d = filt_q;
    fcnt_d = '0;
    // a change is accepted only after FILT_LEN mismatching samples
    if (s != filt_q) begin
      if (fcnt_q == F_LAST)
        filt_d = s;
      else
        fcnt_d = fcnt_q + 1'b1;
    end
    vcnt_d = (vcnt_q == V_LAST) ? vcnt_q
                                : vcnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      fcnt_q <= '0;
      vcnt_q <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      fcnt_q <= fcnt_d;
      vcnt_q <= vcnt_d;
      filt_q <= filt_d;
    end
  end

  assign dout  = filt_q;
  assign valid = (vcnt_q == V_LAST);

endmodule

// File: rtl/quad_enc_ctr.sv
// Quadrature decoder and position counter with x1/x2/x4 modes.
// Optional index capture/clear on z is enabled by QENC_INDEX_EN.
module quad_enc_ctr
  import quad_enc_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
`ifdef QENC_INDEX_EN
  input  logic             z,
  output logic [CNT_W-1:0] idx_pos,
`endif
  input  logic [1:0]       mode,
  input  logic             clr,
  input  logic             err_clr,
  output logic [CNT_W-1:0] cnt,
  output logic             dir,
  output logic             step,
  output logic             err
);

  logic a_f, b_f, a_v, b_v, vld;
  qenc_state_t curr;
  qenc_dec_t   dec;
  logic        evt;

  qenc_state_t      prev_q, prev_d;
  logic             primed_q, primed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             err_q, err_d;

  quad_enc_filt #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_filt_a (
    .clk  (clk),
    .rst  (rst),
    .din  (a),
    .dout (a_f),
    .valid(a_v)
  );

  quad_enc_filt #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_filt_b (
    .clk  (clk),
    .rst  (rst),
    .din  (b),
    .dout (b_f),
    .valid(b_v)
  );

`ifdef QENC_INDEX_EN
  logic             z_f, z_v;
  logic             z_prev_q, z_prev_d;
  logic [CNT_W-1:0] idx_q, idx_d;

  quad_enc_filt #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_filt_z (
    .clk  (clk),
    .rst  (rst),
    .din  (z),
    .dout (z_f),
    .valid(z_v)
  );

  assign vld = a_v & b_v & z_v;
`else
  assign vld = a_v & b_v;
`endif

  assign curr = {a_f, b_f};

  always_comb begin
    dec      = qenc_decode(prev_q, curr, mode);
    evt      = primed_q && (curr != prev_q);
    prev_d   = prev_q;
    primed_d = primed_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    step_d   = 1'b0;
    err_d    = err_q;
    // first settled state becomes the reference without counting
    if (!primed_q) begin
      if (vld) begin
        prev_d   = curr;
        primed_d = 1'b1;
      end
    end else begin
      prev_d = curr;
    end
    if (evt && dec.count_en) begin
      cnt_d  = dec.up ? cnt_q + 1'b1 : cnt_q - 1'b1;
      dir_d  = dec.up;
      step_d = 1'b1;
    end
`ifdef QENC_INDEX_EN
    z_prev_d = z_f;
    idx_d    = idx_q;
    if (primed_q && z_f && !z_prev_q &&
        curr == ST_11) begin
      idx_d = cnt_d;
      cnt_d = '0;
    end
`endif
    if (clr) begin
      cnt_d  = '0;
      step_d = 1'b0;
    end
    if (err_clr)
      err_d = 1'b0;
    if (evt && dec.illegal)
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q   <= ST_00;
      primed_q <= 1'b0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef QENC_INDEX_EN
      z_prev_q <= 1'b0;
      idx_q    <= '0;
`endif
    end else begin
      prev_q   <= prev_d;
      primed_q <= primed_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      err_q    <= err_d;
`ifdef QENC_INDEX_EN
      z_prev_q <= z_prev_d;
      idx_q    <= idx_d;
`endif
    end
  end

  assign cnt  = cnt_q;
  assign dir  = dir_q;
  assign step = step_q;
  assign err  = err_q;
`ifdef QENC_INDEX_EN
  assign idx_pos = idx_q;
`endif

endmodule

// File: tb/tb_quad_enc_ctr.sv
// Scoreboard bench for quad_enc_ctr: ring-position reference model,
// directed scenarios followed by a randomized walk with glitches.
module tb_quad_enc_ctr;

  logic       clk = 1'b0;
  logic       rst, a, b, clr, err_clr;
  logic [1:0] mode;
  logic [7:0] cnt;
  logic       dir, step, err;
`ifdef QENC_INDEX_EN
  logic       z;
  logic [7:0] idx_pos;
  logic [7:0] m_idx;
`endif

  always #5 clk = ~clk;

  quad_enc_ctr #(
    .CNT_W      (8),
    .SYNC_STAGES(2),
    .FILT_LEN   (3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
`ifdef QENC_INDEX_EN
    .z      (z),
    .idx_pos(idx_pos),
`endif
    .mode   (mode),
    .clr    (clr),
    .err_clr(err_clr),
    .cnt    (cnt),
    .dir    (dir),
    .step   (step),
    .err    (err)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int obs_steps = 0;

  logic [8:0] exp_q[$];
  logic [8:0] e;
  logic [1:0] m_st;
  logic [7:0] m_cnt;
  logic       m_dir, m_err;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  function automatic int ring_pos(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] ring_at(input int p);
    logic [1:0] r [4];
    r = '{2'b00, 2'b10, 2'b11, 2'b01};
    return r[p & 3];
  endfunction

  function automatic logic [1:0] fwd(input logic [1:0] s);
    return ring_at(ring_pos(s) + 1);
  endfunction

  function automatic logic [1:0] rev(input logic [1:0] s);
    return ring_at(ring_pos(s) + 3);
  endfunction

  // expected position change from ring distance and mode
  task automatic model(input logic [1:0] nx);
    int   d;
    logic up, cnts;
    d = (ring_pos(nx) - ring_pos(m_st)) & 3;
    if (d == 2) begin
      m_err = 1'b1;
    end else if (d != 0) begin
      up = (d == 1);
      if (mode == 2'd0)
        cnts = (ring_pos(m_st) + ring_pos(nx)) == 1;
      else if (mode == 2'd1)
        cnts = nx[1] != m_st[1];
      else
        cnts = 1'b1;
      if (cnts) begin
        m_cnt = up ? m_cnt + 8'd1 : m_cnt - 8'd1;
        m_dir = up;
        exp_q.push_back({m_dir, m_cnt});
      end
    end
    m_st = nx;
  endtask

  always @(negedge clk) begin
    if (step) begin
      obs_steps++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_step: got cnt=%0h, required no step", cnt);
      end else begin
        e = exp_q.pop_front();
        check("step_cnt", int'(cnt), int'(e[7:0]));
        check("step_dir", int'(dir), int'(e[8]));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic move(input logic [1:0] st, input int gap);
    model(st);
    @(posedge clk);
    #1 {a, b} = st;
    idle(gap);
  endtask

  task automatic do_clr();
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    m_cnt = 8'd0;
    check("clr_cnt", int'(cnt), 0);
  endtask

  task automatic do_errclr();
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    m_err = 1'b0;
    check("errclr_err", int'(err), 0);
  endtask

  task automatic glitch(input bit on_a, input int w);
    @(posedge clk);
    #1;
    if (on_a) a = ~a; else b = ~b;
    repeat (w) @(posedge clk);
    #1;
    if (on_a) a = ~a; else b = ~b;
    idle(8);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_cnt", int'(cnt), 0);
    check("rst_err", int'(err), 0);
    rst = 1'b0;
    exp_q.delete();
    m_cnt = 8'd0;
    m_dir = 1'b0;
    m_err = 1'b0;
    m_st  = {a, b};
  endtask

`ifdef QENC_INDEX_EN
  task automatic load37();
    while (m_st != 2'b10) move(fwd(m_st), 10);
    do_clr();
    repeat (37) move(fwd(m_st), 10);
  endtask
`endif

  int s0, lat;
  int r;

  initial begin
    rst = 1'b1; a = 1'b0; b = 1'b0;
    clr = 1'b0; err_clr = 1'b0; mode = 2'd2;
`ifdef QENC_INDEX_EN
    z = 1'b0; m_idx = 8'd0;
`endif
    m_st = 2'b00; m_cnt = 8'd0;
    m_dir = 1'b0; m_err = 1'b0;
    idle(3);
    check("reset_cnt", int'(cnt), 0);
    check("reset_dir", int'(dir), 0);
    check("reset_step", int'(step), 0);
    check("reset_err", int'(err), 0);
    rst = 1'b0;
    idle(12);

    // x4, four forward cycles, first-edge latency
    mode = 2'd2;
    s0 = obs_steps;
    model(2'b10);
    @(posedge clk);
    #1 {a, b} = 2'b10;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (step && lat == 0) lat = k;
    end
    check("s1_latency", lat, 6);
    repeat (15) move(fwd(m_st), 10);
    check("s1_cnt", int'(cnt), 16);
    check("s1_dir", int'(dir), 1);
    check("s1_steps", obs_steps - s0, 16);

    // x1, three up then three down
    do_clr();
    mode = 2'd0;
    s0 = obs_steps;
    repeat (12) move(fwd(m_st), 10);
    check("s2_peak", int'(cnt), 3);
    repeat (12) move(rev(m_st), 10);
    check("s2_cnt", int'(cnt), 0);
    check("s2_dir", int'(dir), 0);
    check("s2_steps", obs_steps - s0, 6);

    // wrap below zero and back
    mode = 2'd2;
    move(2'b01, 10);
    check("s3_wrap_dn", int'(cnt), 8'hFF);
    check("s3_dir", int'(dir), 0);
    move(2'b00, 10);
    check("s3_wrap_up", int'(cnt), 8'h00);

    // glitch rejection, illegal jump, error clear
    s0 = obs_steps;
    glitch(1'b1, 2);
    check("s4_glitch_cnt", int'(cnt), int'(m_cnt));
    check("s4_glitch_steps", obs_steps - s0, 0);
    move(2'b11, 10);
    check("s4_err", int'(err), 1);
    check("s4_err_cnt", int'(cnt), int'(m_cnt));
    do_errclr();

    // power-up at 11 primes without counting
    s0 = obs_steps;
    do_reset();
    idle(12);
    check("s5_prime_steps", obs_steps - s0, 0);
    move(2'b01, 10);
    check("s5_cnt", int'(cnt), 1);
    do_reset();
    idle(12);

    // randomized walk with mode changes, glitches, clears
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        glitch(1'($urandom_range(0, 1)), $urandom_range(1, 2));
      end else if (r < 14) begin
        do_clr();
      end else if (r < 18) begin
        move(m_st ^ 2'b11, $urandom_range(7, 14));
        check("rnd_err", int'(err), int'(m_err));
        do_errclr();
      end else begin
        if (r < 30) mode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 2) != 0)
          move(fwd(m_st), $urandom_range(7, 14));
        else
          move(rev(m_st), $urandom_range(7, 14));
      end
      check("rnd_cnt", int'(cnt), int'(m_cnt));
    end

`ifdef QENC_INDEX_EN
    mode = 2'd2;
    load37();
    @(posedge clk);
    #1 z = 1'b1;
    idle(10);
    m_idx = m_cnt;
    m_cnt = 8'd0;
    check("s6_idx", int'(idx_pos), int'(m_idx));
    check("s6_idx37", int'(idx_pos), 37);
    check("s6_cnt", int'(cnt), 0);
    z = 1'b0;
    idle(10);
    load37();
    @(posedge clk);
    #1 z = 1'b1;
    repeat (5) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    m_idx = m_cnt;
    m_cnt = 8'd0;
    idle(6);
    check("s6_clr_cnt", int'(cnt), 0);
    check("s6_clr_idx", int'(idx_pos), int'(m_idx));
    z = 1'b0;
    idle(10);
`endif

    idle(10);
    check("sb_drain", exp_q.size(), 0);
    check("final_cnt", int'(cnt), int'(m_cnt));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
